// File: rtl/tpm_pkg.sv
// Shared TPM self-test definitions: sizing, scheduler state encoding and
// algorithm test-id constants.
package tpm_pkg;
  localparam int TPM_NUM_TESTS      = 40;
  localparam int TPM_ID_W           = 6;
  localparam int TPM_TIMEOUT_CYCLES = 4096;

  localparam logic TPMI_YES = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SCAN  = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_FIN   = 3'd4
  } selftest_state_t;

  // Algorithm test ids as seen by the crypto test engine
  localparam int TEST_ID_RSA    = 0;
  localparam int TEST_ID_SHA1   = 1;
  localparam int TEST_ID_HMAC   = 2;
  localparam int TEST_ID_AES    = 3;
  localparam int TEST_ID_SHA256 = 4;
  localparam int TEST_ID_ECC    = 5;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction
endpackage

// File: rtl/tpm_lowest_set_bit.sv
// Combinational priority encoder: index of the lowest set bit of vec.
module tpm_lowest_set_bit #(
  parameter int WIDTH = 40,
  parameter int ID_W  = 6
) (
  input  logic [WIDTH-1:0] vec,
  output logic             valid,
  output logic [ID_W-1:0]  index
);
  always_comb begin
    valid = |vec;
    index = '0;
    // Walk downwards so the lowest set bit is the last one written
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vec[i]) index = ID_W'(i);
    end
  end
endmodule

// File: rtl/tpm_selftest_scheduler.sv
// Sequences TPM algorithm self-tests one at a time over a req/ack/done
// handshake and keeps the testsRun / testsPassed / untested counts.
module tpm_selftest_scheduler
  import tpm_pkg::*;
#(
  parameter int NUM_TESTS      = TPM_NUM_TESTS,
  parameter int ID_W           = TPM_ID_W,
  parameter int TIMEOUT_CYCLES = TPM_TIMEOUT_CYCLES
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 full_test,
  input  logic [NUM_TESTS-1:0] to_test,
  input  logic                 abort,
  output logic                 test_req,
  output logic [ID_W-1:0]      test_id,
  input  logic                 test_ack,
  input  logic                 test_done,
  input  logic                 test_pass,
  output logic                 busy,
  output logic                 done,
  output logic                 failed,
  output logic                 timed_out,
  output logic [15:0]          testsRun,
  output logic [15:0]          testsPassed,
  output logic [15:0]          untested
);
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

  selftest_state_t state, next_state;

  logic [NUM_TESTS-1:0] pending, tested;
  logic [CW-1:0]        tmo_cnt;
  logic                 scan_valid;
  logic [ID_W-1:0]      scan_id;
  logic                 accept, finish, fin_pass, fin_tmo;
  logic [15:0]          pop;

  tpm_lowest_set_bit #(.WIDTH(NUM_TESTS), .ID_W(ID_W)) u_lsb (
    .vec  (pending),
    .valid(scan_valid),
    .index(scan_id)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    finish     = 1'b0;
    fin_pass   = 1'b0;
    fin_tmo    = 1'b0;
    case (state)
      ST_IDLE: if (start) begin
        accept     = 1'b1;
        next_state = ST_SCAN;
      end
      ST_SCAN: next_state = scan_valid ? ST_ISSUE : ST_FIN;
      ST_ISSUE: if (test_ack) begin
        // A done in the ack cycle is handled exactly as in WAIT
        if (test_done) begin
          finish     = 1'b1;
          fin_pass   = test_pass;
          next_state = test_pass ? ST_SCAN : ST_FIN;
        end else begin
          next_state = ST_WAIT;
        end
      end
      ST_WAIT: if (test_done) begin
        finish     = 1'b1;
        fin_pass   = test_pass;
        next_state = test_pass ? ST_SCAN : ST_FIN;
      end else if (tmo_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
        finish     = 1'b1;
        fin_tmo    = 1'b1;
        next_state = ST_FIN;
      end
      ST_FIN:  next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
    // abort beats everything, including a start in IDLE
    if (abort) begin
      next_state = ST_IDLE;
      accept     = 1'b0;
      finish     = 1'b0;
      fin_pass   = 1'b0;
      fin_tmo    = 1'b0;
    end
  end

  assign test_req = (state == ST_ISSUE);
  assign busy     = (state == ST_SCAN) || (state == ST_ISSUE) || (state == ST_WAIT);

  always_comb begin
    pop = '0;
    for (int i = 0; i < NUM_TESTS; i++) pop = pop + 16'(tested[i]);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pending     <= '0;
      tested      <= '0;
      test_id     <= '0;
      tmo_cnt     <= '0;
      testsRun    <= '0;
      testsPassed <= '0;
      failed      <= 1'b0;
      timed_out   <= 1'b0;
      done        <= 1'b0;
      untested    <= 16'(NUM_TESTS);
    end else begin
      done     <= (state == ST_FIN) && !abort;
      untested <= 16'(NUM_TESTS) - pop;

      if (state == ST_ISSUE && test_ack) tmo_cnt <= '0;
      else if (state == ST_WAIT)         tmo_cnt <= tmo_cnt + CW'(1);

      if (state == ST_SCAN && scan_valid) test_id <= scan_id;

      if (accept) begin
        testsRun    <= '0;
        testsPassed <= '0;
        failed      <= 1'b0;
        timed_out   <= 1'b0;
        if (full_test == TPMI_YES) begin
          pending <= '1;
          tested  <= '0;
        end else begin
          pending <= to_test & ~tested;
        end
      end

      if (finish) begin
        testsRun         <= sat_inc(testsRun);
        pending[test_id] <= 1'b0;
        if (fin_pass) begin
          testsPassed     <= sat_inc(testsPassed);
          tested[test_id] <= 1'b1;
        end else begin
          failed <= 1'b1;
          if (fin_tmo) timed_out <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_tpm_selftest_scheduler.sv
// Scoreboard bench: random engine behaviour per test id, expected issue order
// and end-of-sequence counts computed from the command rules and queued.
module tb_tpm_selftest_scheduler;
  import tpm_pkg::*;

  localparam int N   = TPM_NUM_TESTS;
  localparam int IDW = TPM_ID_W;
  localparam int TMO = 16;

  logic           clock = 1'b0;
  logic           reset_n = 1'b0;
  logic           start = 1'b0, full_test = 1'b0, abort = 1'b0;
  logic [N-1:0]   to_test = '0;
  logic           test_ack = 1'b0, test_done = 1'b0, test_pass = 1'b0;
  logic           test_req, busy, done, failed, timed_out;
  logic [IDW-1:0] test_id;
  logic [15:0]    testsRun, testsPassed, untested;

  tpm_selftest_scheduler #(.NUM_TESTS(N), .ID_W(IDW), .TIMEOUT_CYCLES(TMO)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .full_test(full_test),
    .to_test(to_test), .abort(abort), .test_req(test_req), .test_id(test_id),
    .test_ack(test_ack), .test_done(test_done), .test_pass(test_pass),
    .busy(busy), .done(done), .failed(failed), .timed_out(timed_out),
    .testsRun(testsRun), .testsPassed(testsPassed), .untested(untested)
  );

  always #5 clock = ~clock;

  typedef struct {
    int run;
    int passed;
    int untested;
    bit failed;
    bit tmo;
  } res_t;

  int     total = 0, bad = 0;
  int     exp_ids[$];
  res_t   exp_res[$];
  int     outcome[N];      // 0 pass, 1 fail, 2 engine never answers
  bit [N-1:0] m_tested;
  int     m_run, m_passed;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model: which ids get issued, in what order, and final counts.
  // stop_id marks a test that will be interrupted (abort/reset): no result.
  function automatic void plan(input bit full, input bit [N-1:0] mask, input int stop_id);
    bit [N-1:0] pend;
    res_t r;
    r.failed = 0;
    r.tmo    = 0;
    if (full) begin
      m_tested = '0;
      pend     = '1;
    end else begin
      pend = mask & ~m_tested;
    end
    m_run = 0;
    m_passed = 0;
    for (int i = 0; i < N; i++) begin
      if (pend[i]) begin
        exp_ids.push_back(i);
        if (i == stop_id) return;
        m_run++;
        if (outcome[i] == 0) begin
          m_passed++;
          m_tested[i] = 1'b1;
        end else begin
          r.failed = 1;
          r.tmo    = (outcome[i] == 2);
          break;
        end
      end
    end
    r.run      = m_run;
    r.passed   = m_passed;
    r.untested = N - $countones(m_tested);
    exp_res.push_back(r);
  endfunction

  // Test engine: random ack delay, random done delay (0 = same cycle as ack)
  initial begin
    int eng, dly, ddly, cur;
    eng = 0; dly = 0; ddly = 0; cur = 0;
    forever begin
      @(negedge clock);
      test_ack = 0; test_done = 0; test_pass = 0;
      if (!reset_n) begin
        eng = 0;
      end else begin
        if (eng == 0 && test_req) begin
          cur = int'(test_id);
          dly = $urandom_range(0, 2);
          eng = 1;
        end else if (eng == 2) begin
          if (ddly <= 1) begin
            test_done = 1; test_pass = (outcome[cur] == 0); eng = 0;
          end else ddly--;
        end
        if (eng == 1) begin
          if (!test_req) eng = 0;
          else if (dly == 0) begin
            test_ack = 1;
            if (outcome[cur] == 2) eng = 0;
            else begin
              ddly = $urandom_range(0, 4);
              if (ddly == 0) begin
                test_done = 1; test_pass = (outcome[cur] == 0); eng = 0;
              end else eng = 2;
            end
          end else dly--;
        end
      end
    end
  end

  // Monitor: pops expectations whenever the DUT issues a test or signals done
  initial begin
    bit   prev_req;
    res_t r;
    prev_req = 0;
    forever begin
      @(negedge clock);
      if (test_req && !prev_req) begin
        if (exp_ids.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_req: got id %0d, expected no request", test_id);
        end else chk("test_id", 32'(test_id), 32'(exp_ids.pop_front()));
      end
      prev_req = test_req;
      if (done) begin
        if (exp_res.size() == 0) begin
          total++; bad++;
          $display("FAIL spurious_done: got done=1, expected 0");
        end else begin
          r = exp_res.pop_front();
          chk("testsRun",    32'(testsRun),    32'(r.run));
          chk("testsPassed", 32'(testsPassed), 32'(r.passed));
          chk("untested",    32'(untested),    32'(r.untested));
          chk("failed",      32'(failed),      32'(r.failed));
          chk("timed_out",   32'(timed_out),   32'(r.tmo));
          chk("busy_at_done", 32'(busy), 32'd0);
        end
      end
      if (testsPassed > testsRun) begin
        total++; bad++;
        $display("FAIL passed_le_run: got passed=%0d run=%0d", testsPassed, testsRun);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clock);
  endtask

  task automatic issue(input bit full, input bit [N-1:0] mask, input int stop_id);
    plan(full, mask, stop_id);
    start = 1; full_test = full; to_test = mask;
    tick();
    start = 0;
  endtask

  task automatic wait_done(input string name, input int budget, output int cyc);
    cyc = 0;
    while (!done && cyc < budget) begin
      tick(); cyc++;
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL %s: got no done, expected done within %0d cycles", name, budget);
    end
    tick();
  endtask

  task automatic wait_id(input int id);
    int n = 0;
    while (!(test_req && test_id == IDW'(id)) && n < 200) begin
      tick(); n++;
    end
    chk("reached_id", 32'(test_req && test_id == IDW'(id)), 32'd1);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_req"},       32'(test_req),    32'd0);
    chk({tag, "_busy"},      32'(busy),        32'd0);
    chk({tag, "_done"},      32'(done),        32'd0);
    chk({tag, "_failed"},    32'(failed),      32'd0);
    chk({tag, "_timed_out"}, 32'(timed_out),   32'd0);
    chk({tag, "_run"},       32'(testsRun),    32'd0);
    chk({tag, "_passed"},    32'(testsPassed), 32'd0);
    chk({tag, "_untested"},  32'(untested),    32'(N));
    chk({tag, "_id"},        32'(test_id),     32'd0);
  endtask

  initial begin
    int cyc;
    bit [N-1:0] m37;
    logic [63:0] r64;
    for (int i = 0; i < N; i++) outcome[i] = 0;
    m37 = '0; m37[3] = 1'b1; m37[7] = 1'b1;

    tick(2);
    check_reset("reset");
    reset_n = 1; tick();

    // Full pass, with start latency checks
    issue(1, '0, -1);
    chk("busy_after_start", 32'(busy), 32'd1);
    chk("req_before_2cyc", 32'(test_req), 32'd0);
    tick();
    chk("req_at_2cyc", 32'(test_req), 32'd1);
    wait_done("full_pass", 800, cyc);

    // Reset, then incremental {7,3}, then repeat (already tested -> empty)
    reset_n = 0; m_tested = '0; tick(); reset_n = 1; tick();
    issue(0, m37, -1);
    wait_done("incr_37", 200, cyc);
    issue(0, m37, -1);
    chk("empty_done_c1", 32'(done), 32'd0);
    tick();
    chk("empty_done_c2", 32'(done), 32'd0);
    tick();
    chk("empty_done_c3", 32'(done), 32'd1);
    wait_done("incr_empty", 10, cyc);

    // Full test failing on id 5
    outcome[5] = 1;
    issue(1, '0, -1);
    wait_done("fail5", 400, cyc);
    tick(5);
    outcome[5] = 0;

    // Timeout on id 0
    outcome[0] = 2;
    issue(1, '0, -1);
    wait_done("timeout", 200, cyc);
    chk("timeout_latency_ge", 32'(cyc >= TMO), 32'd1);
    outcome[0] = 0;

    // Abort while waiting on id 2; counters hold, no done
    outcome[2] = 2;
    issue(1, '0, 2);
    wait_id(2);
    tick(6);
    abort = 1; tick(); abort = 0;
    chk("abort_busy",   32'(busy),        32'd0);
    chk("abort_req",    32'(test_req),    32'd0);
    chk("abort_run",    32'(testsRun),    32'(m_run));
    chk("abort_passed", 32'(testsPassed), 32'(m_passed));
    tick(4);
    chk("abort_no_done", 32'(done), 32'd0);
    outcome[2] = 0;
    r64 = {$urandom, $urandom};
    issue(0, r64[N-1:0], -1);
    wait_done("after_abort", 800, cyc);

    // abort and start together in IDLE: start ignored
    start = 1; abort = 1; full_test = 1; tick(); start = 0; abort = 0;
    chk("abort_start_busy", 32'(busy), 32'd0);
    tick(3);

    // Async reset while waiting on id 3
    outcome[3] = 2;
    issue(1, '0, 3);
    wait_id(3);
    tick(5);
    #2 reset_n = 0;
    #1 check_reset("midwait_reset");
    m_tested = '0;
    tick(); reset_n = 1; outcome[3] = 0; tick();

    // Random commands and engine outcomes
    repeat (30) begin
      for (int i = 0; i < N; i++) begin
        int r;
        r = $urandom_range(0, 199);
        outcome[i] = (r < 3) ? 1 : (r < 5) ? 2 : 0;
      end
      r64 = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 1) r64 = r64 & {$urandom, $urandom};
      issue($urandom_range(0, 3) == 0, r64[N-1:0], -1);
      wait_done("random", 800, cyc);
    end

    tick(3);
    chk("ids_drained", 32'(exp_ids.size()), 32'd0);
    chk("res_drained", 32'(exp_res.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
